serial_subtractor: RTL

Bit-serial unsigned subtractor, the inverse-direction companion to the team's ripple adder: computes `a - b` one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It sits beside the adder in the arithmetic library and serves area-constrained datapaths that accept multi-cycle latency. A ready/start/done handshake frames each operation, and the final borrow is reported as `underflow`.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width and
// the FSM state encoding used by the top level.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: computes a - b - in_borrow for one bit
// position and produces the borrow for the next (more significant) bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic in_borrow,
  output logic diff,
  output logic out_borrow
);

  assign diff       = a ^ b ^ in_borrow;
  assign out_borrow = (~a & b) | (~(a ^ b) & in_borrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first through one
// full_subtractor cell, framed by a ready/start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             underflow,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] count;
  logic             borrow;
  logic             bit_diff;
  logic             borrow_next;

  full_subtractor u_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .in_borrow  (borrow),
    .diff       (bit_diff),
    .out_borrow (borrow_next)
  );

  // The result fills from the MSB end, so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {bit_diff, res_sr[WIDTH-1:1]};

  // ready/done are flops updated together with state, keeping them free of any
  // combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      count     <= '0;
      borrow    <= 1'b0;
      diff      <= '0;
      underflow <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= borrow_next;
          count  <= count + 1'b1;
          if (count == LAST_BIT) begin
            diff      <= res_next;
            underflow <= borrow_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
